instr_loader: RTL and testbench
===============================

# instr_loader

Boot-time program loader and ownership controller for the instruction memory. It receives a length-prefixed byte stream from the UART receiver, assembles little-endian 32-bit words, and writes them sequentially into the instruction memory through its I/O port. While loading it holds the memory's I/O select. When loading finishes it hands the memory to the processor, starts the core, and returns an acknowledge byte to the UART transmitter.

## Interface
Parameters:
- ADDR_W, 13: word-address width of the instruction memory; capacity is 2^ADDR_W words.
- ACK_BYTE, 8'hAA: byte sent on successful load.
- NAK_BYTE, 8'hEE: byte sent on length error.

Ports:
- clk  in  1  single clock.
- rstn  in  1  asynchronous, active-low reset.
- rx_valid  in  1  one-cycle strobe; rx_data holds a received byte.
- rx_data  in  8  received byte.
- reload  in  1  one-cycle request to restart loading from S_LEN.
- tx_ready  in  1  transmitter can accept a byte.
- tx_valid  out  1  ack/nak byte valid; held until tx_ready.
- tx_data  out  8  ack/nak byte.
- mem_io_sel  out  1  1 = I/O port owns the instruction memory, 0 = processor.
- mem_we  out  1  write strobe.
- mem_en  out  1  memory enable; equals mem_we while loading, 1 in S_DONE.
- mem_addr  out  32  byte address = word_index·4; bits [1:0] always 0.
- mem_din  out  32  word to write.
- cpu_start  out  1  one-cycle pulse on entering S_DONE.
- cpu_run  out  1  level; processor may fetch.
- busy  out  1  high in S_LEN, S_DATA and S_LAST.
- err  out  1  high in S_ERR.

## Operation
- Protocol: 4 bytes length N (word count, little-endian), then N words, each 4 bytes, least-significant byte first.
- States:
  - S_LEN: gather 4 length bytes. On the 4th byte: N==0 → S_DONE; N>2^ADDR_W → S_ERR; otherwise S_DATA.
  - S_DATA: gather bytes into a shift register with a 2-bit byte counter. On each 4th byte, register mem_din, mem_addr = widx<<2, and mem_we=1 for exactly the next cycle, then increment widx. If the completed word is word N-1 → S_LAST, else stay in S_DATA.
  - S_LAST: the final write cycle. rx bytes are ignored. Next state is S_DONE.
  - S_DONE: mem_io_sel=0, cpu_run=1, cpu_start pulses for 1 cycle on entry, tx_valid=1 with ACK_BYTE until tx_ready. rx bytes are ignored.
  - S_ERR: mem_io_sel=1, cpu_run=0, tx_valid=1 with NAK_BYTE until tx_ready. rx bytes are ignored.
- reload in any state → S_LEN next cycle:
  - clears widx, the byte counter and the length register
  - sets mem_io_sel=1 and drops cpu_run
  - cancels any pending tx_valid.
- reload takes priority over a coincident rx_valid; that byte is dropped.
- tx handshake: the byte transfers on a cycle with tx_valid and tx_ready both high; tx_valid falls the next cycle. Exactly one ack or nak is sent per load attempt.
- Byte counter wraps 3→0. widx is ADDR_W+1 bits wide, so N = 2^ADDR_W is legal and the last address is (2^ADDR_W−1)·4.

## Timing
- Reset values:
  - state=S_LEN, mem_io_sel=1
  - mem_we=0, mem_en=0, mem_addr=0, mem_din=0
  - cpu_start=0, cpu_run=0, tx_valid=0, tx_data=0, err=0
  - busy=1.
- rx_valid may assert on every cycle in S_LEN and S_DATA; no byte is lost.
- 4th byte of word k accepted in cycle t → mem_we=1, mem_addr=4k in cycle t+1. The next word's bytes are accepted during t+1.
- Last word: write in cycle t+1 (S_LAST); in t+2, mem_io_sel=0, cpu_start=1, cpu_run=1, tx_valid=1. mem_io_sel never falls in the same cycle as mem_we.
- N==0: 4th length byte in cycle t → S_DONE outputs in t+1.
- Length error: 4th length byte in cycle t → err=1, tx_valid=1 in t+1.
- rstn asserted mid-load: all outputs return to reset values immediately. Partially written memory is not cleared.

## Test plan
- Length 2, words 0x11223344 and 0xDEADBEEF, bytes 02 00 00 00 44 33 22 11 EF BE AD DE sent back-to-back → two single-cycle writes at addr 0x0 and 0x4 with matching din; in the cycle after the second write, mem_io_sel=0, one cpu_start pulse, tx_data=0xAA.
- Length 0 (00 00 00 00) → no mem_we; S_DONE outputs one cycle after the 4th byte; ack sent.
- Length 8193 (01 20 00 00) → err=1, tx_data=0xEE, mem_io_sel stays 1, cpu_run stays 0, following bytes produce no writes.
- Length 8192, bytes spaced 1–3 cycles apart → last write at addr 0x7FFC; widx does not wrap; ack sent.
- rstn pulsed after 6 bytes of a 3-word load, then a full 1-word load → only the second load's word is written, at addr 0x0.
- tx_ready held low 10 cycles in S_DONE → tx_valid and tx_data stable; one transfer when tx_ready rises; then reload → mem_io_sel=1, cpu_run=0, busy=1.

Source files
------------

// File: rtl/instr_loader.sv
// Boot loader: assembles a length-prefixed little-endian byte stream into 32-bit words,
// writes them into instruction memory, then hands the memory to the core and sends ack/nak.
module instr_loader #(
  parameter int          ADDR_W   = 13,
  parameter logic [7:0]  ACK_BYTE = 8'hAA,
  parameter logic [7:0]  NAK_BYTE = 8'hEE
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        reload,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        mem_io_sel,
  output logic        mem_we,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        cpu_start,
  output logic        cpu_run,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {S_LEN, S_DATA, S_LAST, S_DONE, S_ERR} state_t;

  localparam logic [32:0] CAP = 33'd1 << ADDR_W;

  state_t            r_state, w_nstate;
  logic [1:0]        r_bcnt;
  logic [23:0]       r_shift;
  logic [31:0]       r_len;
  logic [ADDR_W:0]   r_widx;
  logic              r_tx_valid;
  logic [7:0]        r_tx_data;
  logic              r_we;
  logic [31:0]       r_addr;
  logic [31:0]       r_din;
  logic              r_start;

  logic              w_take;
  logic              w_quad;
  logic [31:0]       w_word;
  logic              w_last;
  logic              w_len_done;
  logic              w_word_done;
  logic              w_enter_done;
  logic              w_enter_err;

  // reload wins over a coincident byte, so the byte is never taken
  assign w_take = rx_valid && !reload && (r_state == S_LEN || r_state == S_DATA);
  assign w_quad = w_take && (r_bcnt == 2'd3);
  assign w_word = {rx_data, r_shift};
  assign w_last = (32'(r_widx) + 32'd1) == r_len;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_LEN;
    else       r_state <= w_nstate;
  end

  always_comb begin
    w_nstate    = r_state;
    w_len_done  = 1'b0;
    w_word_done = 1'b0;
    if (reload) begin
      w_nstate = S_LEN;
    end else begin
      unique case (r_state)
        S_LEN: if (w_quad) begin
          w_len_done = 1'b1;
          if (w_word == 32'd0)               w_nstate = S_DONE;
          else if ({1'b0, w_word} > CAP)     w_nstate = S_ERR;
          else                               w_nstate = S_DATA;
        end
        S_DATA: if (w_quad) begin
          w_word_done = 1'b1;
          if (w_last) w_nstate = S_LAST;
        end
        S_LAST:  w_nstate = S_DONE;
        default: w_nstate = r_state;
      endcase
    end
  end

  assign w_enter_done = (w_nstate == S_DONE) && (r_state != S_DONE);
  assign w_enter_err  = (w_nstate == S_ERR)  && (r_state != S_ERR);

  // Byte assembly: the three older bytes sit in r_shift, the newest arrives on rx_data
  always_ff @(posedge clk) begin
    if (w_take) r_shift <= {rx_data, r_shift[23:8]};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_bcnt     <= 2'd0;
      r_len      <= 32'd0;
      r_widx     <= '0;
      r_we       <= 1'b0;
      r_addr     <= 32'd0;
      r_din      <= 32'd0;
      r_start    <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'd0;
    end else begin
      r_we    <= w_word_done;
      r_start <= w_enter_done;
      if (reload) begin
        r_bcnt     <= 2'd0;
        r_len      <= 32'd0;
        r_widx     <= '0;
        r_tx_valid <= 1'b0;
      end else begin
        if (w_take)     r_bcnt <= r_bcnt + 2'd1;
        if (w_len_done) r_len  <= w_word;
        if (w_word_done) begin
          r_din  <= w_word;
          r_addr <= 32'(r_widx) << 2;
          r_widx <= r_widx + 1'b1;
        end
        if (w_enter_done) begin
          r_tx_valid <= 1'b1;
          r_tx_data  <= ACK_BYTE;
        end else if (w_enter_err) begin
          r_tx_valid <= 1'b1;
          r_tx_data  <= NAK_BYTE;
        end else if (r_tx_valid && tx_ready) begin
          r_tx_valid <= 1'b0;
        end
      end
    end
  end

  assign tx_valid   = r_tx_valid;
  assign tx_data    = r_tx_data;
  assign mem_io_sel = (r_state != S_DONE);
  assign mem_we     = r_we;
  assign mem_en     = r_we | (r_state == S_DONE);
  assign mem_addr   = r_addr;
  assign mem_din    = r_din;
  assign cpu_start  = r_start;
  assign cpu_run    = (r_state == S_DONE);
  assign busy       = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_LAST);
  assign err        = (r_state == S_ERR);

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: byte-stream reference model checked every cycle,
// plus literal expectations on the write log and ack/nak traffic per scenario.
module tb_instr_loader;

  logic        clk;
  logic        rstn;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        reload;
  logic        tx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        mem_io_sel;
  logic        mem_we;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        cpu_start;
  logic        cpu_run;
  logic        busy;
  logic        err;

  instr_loader dut (
    .clk(clk), .rstn(rstn), .rx_valid(rx_valid), .rx_data(rx_data),
    .reload(reload), .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .mem_io_sel(mem_io_sel), .mem_we(mem_we), .mem_en(mem_en),
    .mem_addr(mem_addr), .mem_din(mem_din), .cpu_start(cpu_start),
    .cpu_run(cpu_run), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: protocol position is tracked as a plain count of accepted bytes
  logic [7:0]  m_buf [4];
  int          m_cnt = 0;
  logic [31:0] m_len = 0;
  logic        m_acc = 1, m_fin = 0, m_cpu = 0, m_err = 0, m_txv = 0, m_start = 0, m_we = 0;
  logic [7:0]  m_txd = 0;
  logic [31:0] m_addr = 0, m_din = 0;
  logic [31:0] m_w;
  int          m_k;

  // Observation log
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          xfer_cnt = 0, start_cnt = 0, cyc = 0, we_cyc = 0, st_cyc = 0;
  logic [7:0]  last_tx = 0;
  logic        p_txv = 0;
  logic [7:0]  p_txd = 0;
  logic [79:0] act_v, exp_v;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic do_reload();
    @(negedge clk);
    rx_valid = 1'b0;
    reload   = 1'b1;
    @(negedge clk);
    reload   = 1'b0;
  endtask

  task automatic model_step();
    if (!rstn) begin
      m_cnt = 0; m_len = 0; m_acc = 1; m_fin = 0; m_cpu = 0; m_err = 0;
      m_txv = 0; m_txd = 0; m_start = 0; m_we = 0; m_addr = 0; m_din = 0;
    end else begin
      m_start = 0;
      m_we    = 0;
      if (reload) begin
        m_cnt = 0; m_len = 0; m_acc = 1; m_fin = 0; m_cpu = 0; m_err = 0; m_txv = 0;
      end else begin
        if (m_txv && tx_ready) m_txv = 0;
        if (m_fin) begin
          m_fin = 0; m_cpu = 1; m_start = 1; m_txv = 1; m_txd = 8'hAA;
        end else if (m_acc && rx_valid) begin
          m_buf[m_cnt % 4] = rx_data;
          m_cnt++;
          if (m_cnt % 4 == 0) begin
            m_w = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
            if (m_cnt == 4) begin
              if (m_w == 0) begin
                m_acc = 0; m_cpu = 1; m_start = 1; m_txv = 1; m_txd = 8'hAA;
              end else if (m_w > 32'd8192) begin
                m_acc = 0; m_err = 1; m_txv = 1; m_txd = 8'hEE;
              end else begin
                m_len = m_w;
              end
            end else begin
              m_k    = m_cnt / 4 - 2;
              m_we   = 1;
              m_addr = m_k * 4;
              m_din  = m_w;
              if (m_k + 1 == m_len) begin
                m_acc = 0;
                m_fin = 1;
              end
            end
          end
        end
      end
    end
  endtask

  initial begin
    int b_wr, b_st, b_xf;
    logic [31:0] w;
    int g;
    rstn = 1'b0; rx_valid = 1'b0; rx_data = 8'd0; reload = 1'b0; tx_ready = 1'b1;
    fork
      forever begin
        @(posedge clk);
        if (rstn && p_txv && tx_ready) begin
          xfer_cnt++;
          last_tx = p_txd;
        end
        model_step();
        #1;
        cyc++;
        act_v = {tx_valid, tx_data, mem_io_sel, mem_we, mem_en, mem_addr, mem_din,
                 cpu_start, cpu_run, busy, err};
        exp_v = {m_txv, m_txd, !m_cpu, m_we, m_we | m_cpu, m_addr, m_din,
                 m_start, m_cpu, m_acc | m_fin, m_err};
        n_chk++;
        if (act_v !== exp_v) begin
          n_err++;
          $display("FAIL cycle %0d outputs: got %h expected %h", cyc, act_v, exp_v);
        end
        if (mem_we) begin
          wa_q.push_back(mem_addr);
          wd_q.push_back(mem_din);
          we_cyc = cyc;
        end
        if (cpu_start) begin
          start_cnt++;
          st_cyc = cyc;
        end
        p_txv = tx_valid;
        p_txd = tx_data;
      end
      begin
        repeat (100000) @(posedge clk);
        n_chk++;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
      end
      begin
        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_io_sel", 32'(mem_io_sel), 32'd1);
        chk("rst_en_we", {30'd0, mem_en, mem_we}, 32'd0);
        chk("rst_tx", {23'd0, tx_valid, tx_data}, 32'd0);
        chk("rst_run_err", {30'd0, cpu_run, err}, 32'd0);
        rstn = 1'b1;

        // Two-word load, back to back
        b_wr = wa_q.size(); b_st = start_cnt; b_xf = xfer_cnt;
        send(8'h02); send(8'h00); send(8'h00); send(8'h00);
        send(8'h44); send(8'h33); send(8'h22); send(8'h11);
        send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        idle(5);
        chk("t1_nwrites", wa_q.size() - b_wr, 32'd2);
        chk("t1_addr0", wa_q[b_wr], 32'h0);
        chk("t1_din0", wd_q[b_wr], 32'h11223344);
        chk("t1_addr1", wa_q[b_wr + 1], 32'h4);
        chk("t1_din1", wd_q[b_wr + 1], 32'hDEADBEEF);
        chk("t1_start_pulses", start_cnt - b_st, 32'd1);
        chk("t1_start_after_write", st_cyc, we_cyc + 1);
        chk("t1_xfers", xfer_cnt - b_xf, 32'd1);
        chk("t1_ack", {24'd0, last_tx}, 32'hAA);

        // Zero-length load
        do_reload();
        b_wr = wa_q.size(); b_st = start_cnt; b_xf = xfer_cnt;
        send(8'h00); send(8'h00); send(8'h00); send(8'h00);
        idle(4);
        chk("t2_nwrites", wa_q.size() - b_wr, 32'd0);
        chk("t2_start_pulses", start_cnt - b_st, 32'd1);
        chk("t2_xfers", xfer_cnt - b_xf, 32'd1);
        chk("t2_ack", {24'd0, last_tx}, 32'hAA);

        // Oversized length 8193 followed by stray bytes
        do_reload();
        b_wr = wa_q.size(); b_xf = xfer_cnt;
        send(8'h01); send(8'h20); send(8'h00); send(8'h00);
        for (int i = 0; i < 8; i++) send(8'(i + 1));
        idle(4);
        chk("t3_err", 32'(err), 32'd1);
        chk("t3_io_sel", 32'(mem_io_sel), 32'd1);
        chk("t3_run", 32'(cpu_run), 32'd0);
        chk("t3_nwrites", wa_q.size() - b_wr, 32'd0);
        chk("t3_xfers", xfer_cnt - b_xf, 32'd1);
        chk("t3_nak", {24'd0, last_tx}, 32'hEE);

        // Full-capacity load, 8192 words, irregular byte spacing
        do_reload();
        b_wr = wa_q.size(); b_xf = xfer_cnt;
        send(8'h00); send(8'h20); send(8'h00); send(8'h00);
        for (int k = 0; k < 8192; k++) begin
          w = 32'h5A000000 | 32'(k);
          for (int b = 0; b < 4; b++) begin
            send(w[8*b +: 8]);
            g = ((4*k + b) % 16 == 5) ? 3 : (((4*k + b) % 16 == 11) ? 2 : 1);
            if (g > 1) idle(g - 1);
          end
        end
        idle(5);
        chk("t4_nwrites", wa_q.size() - b_wr, 32'd8192);
        chk("t4_first_addr", wa_q[b_wr], 32'h0);
        chk("t4_last_addr", wa_q[wa_q.size() - 1], 32'h7FFC);
        chk("t4_last_din", wd_q[wd_q.size() - 1], 32'h5A001FFF);
        chk("t4_xfers", xfer_cnt - b_xf, 32'd1);
        chk("t4_ack", {24'd0, last_tx}, 32'hAA);

        // Reset mid-load, then a clean one-word load
        do_reload();
        b_wr = wa_q.size();
        send(8'h03); send(8'h00); send(8'h00); send(8'h00);
        send(8'h01); send(8'h02);
        @(negedge clk);
        rx_valid = 1'b0;
        rstn     = 1'b0;
        idle(2);
        chk("t5_rst_busy_sel", {30'd0, busy, mem_io_sel}, 32'd3);
        chk("t5_rst_we_din", {31'd0, mem_we} | mem_din, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        send(8'h01); send(8'h00); send(8'h00); send(8'h00);
        send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        idle(5);
        chk("t5_nwrites", wa_q.size() - b_wr, 32'd1);
        chk("t5_addr", wa_q[b_wr], 32'h0);
        chk("t5_din", wd_q[b_wr], 32'h12345678);

        // Stalled transmitter in S_DONE, then reload
        tx_ready = 1'b0;
        do_reload();
        b_xf = xfer_cnt;
        send(8'h01); send(8'h00); send(8'h00); send(8'h00);
        send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        idle(12);
        chk("t6_txv_held", 32'(tx_valid), 32'd1);
        chk("t6_txd_held", {24'd0, tx_data}, 32'hAA);
        chk("t6_no_xfer", xfer_cnt - b_xf, 32'd0);
        @(negedge clk);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        idle(2);
        chk("t6_one_xfer", xfer_cnt - b_xf, 32'd1);
        chk("t6_txv_dropped", 32'(tx_valid), 32'd0);
        do_reload();
        chk("t6_reload_sel", 32'(mem_io_sel), 32'd1);
        chk("t6_reload_run", 32'(cpu_run), 32'd0);
        chk("t6_reload_busy", 32'(busy), 32'd1);
        idle(2);
      end
    join_any
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
